spi_flash_sequencer: RTL and testbench
======================================

Name: spi_flash_sequencer

Overview:
- Command sequencer and arbiter for the shared quad-SPI flash. It sits between two requesters and the single SPI byte engine.
  - Read port: fetch path.
  - Program port: configuration/store path.
- Grants one requester at a time and expands each request into the flash command sequence:
  - Read: READ.
  - Program: WREN, then PAGE PROGRAM, then RDSR busy-poll.
- Owns chip-select timing between commands.
- Runs after the power-up status-register init has completed (start gated by init_done).

Parameters:
- DATA_SIZE, 32, bits per read/program transaction; multiple of 8, range 8..64.
- CS_GAP, 2, minimum ACLK cycles spi_cs_n stays high between two commands.
- POLL_MAX, 1023, maximum status bytes read in one busy-poll before timeout.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- init_done  in  1  level; no grant is issued while 0.
- rd_req  in  1  read request; held until rd_ack.
- rd_addr  in  24  flash byte address; latched at grant.
- rd_ack  out  1  one-cycle pulse; rd_data is valid in the same cycle.
- rd_data  out  DATA_SIZE  read word, first byte in the MSBs; held until the next rd_ack.
- wr_req  in  1  program request; held until wr_ack.
- wr_addr  in  24  flash byte address; latched at grant.
- wr_data  in  DATA_SIZE  program word, sent MSB byte first; latched at grant.
- wr_ack  out  1  one-cycle pulse at program completion.
- wr_err  out  1  valid with wr_ack; 1 = busy-poll timeout.
- byte_start  out  1  one-cycle pulse; launches one byte on the engine.
- byte_tx  out  8  byte to shift out; stable from byte_start until byte_done.
- byte_done  in  1  one-cycle pulse from the engine.
- byte_rx  in  8  byte shifted in; valid with byte_done.
- spi_cs_n  out  1  flash chip select, active-low.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset:
  - All outputs 0 except spi_cs_n=1.
  - rd_data=0; state IDLE; last_grant=WRITE, so the first contention goes to read.
  - Async assertion mid-transfer clears everything immediately.
  - A byte_done arriving after reset release is ignored.
- Engine handshake:
  - At most one byte outstanding.
  - The next byte_start is issued no earlier than the cycle after byte_done.
  - byte_done while not waiting is ignored.
- Chip select:
  - spi_cs_n goes low in the cycle byte_start is first asserted for a command.
  - It returns high in the cycle after that command's last byte_done.
  - It stays high for CS_GAP cycles before the next command's first byte_start.
- States: IDLE, GRANT, WREN, GAP1, PROG, GAP2, POLL, RD, DONE.
- IDLE:
  - Arbitration happens only when init_done=1.
  - If only one request is present, grant it.
  - If both are present, grant the one not equal to last_grant.
  - On the next cycle, GRANT latches address/data and sets last_grant.
- Read path:
  - GRANT goes to RD.
  - RD sends 03h, A[23:16], A[15:8], A[7:0], then DATA_SIZE/8 bytes of 00h.
  - rx bytes from the dummy phase are shifted into rd_data MSB-first.
  - RD then goes to DONE.
  - DONE pulses rd_ack for 1 cycle and returns to IDLE.
- Program path:
  - WREN sends one byte, 06h; then GAP1.
  - PROG sends 02h, 3 address bytes, then DATA_SIZE/8 data bytes; then GAP2.
  - POLL sends 05h, then reads status bytes with CS held low.
    - On a byte_rx[0]=0 (WIP clear): raise CS, DONE, wr_ack=1, wr_err=0.
    - After POLL_MAX status bytes with WIP still 1: raise CS, DONE, wr_ack=1, wr_err=1.
- Poll counter: 10 bits, saturating check at POLL_MAX; the count excludes the 05h opcode byte.
- A requester dropping req before ack:
  - The transaction still completes and the ack still pulses.
  - A new grant requires req=1 in IDLE.
- A request arriving during a busy transaction waits; no preemption.
- The ack pulse and the next grant:
  - The ack pulse cycle is in DONE.
  - Earliest next grant decision is the following IDLE cycle, so there is a 1 idle cycle minimum.
- Byte counter: sized for 4+DATA_SIZE/8 ≤ 12 bytes; no wrap within a command.

Test Plan:
- Read (engine done 16 cycles after start, rd_addr=0x012345, dummy rx bytes DE,AD,BE,EF):
  - byte_tx sequence 03,01,23,45,00,00,00,00 under one CS-low window.
  - rd_ack with rd_data=0xDEADBEEF.
- Program (wr_addr=0x000100, wr_data=0xA5A55A5A, status rx 03,03,00):
  - Three CS windows with bytes [06], [02,00,01,00,A5,A5,5A,5A], [05,st,st,st].
  - Each CS window separated by ≥2 high cycles.
  - wr_ack=1, wr_err=0.
- Timeout, POLL_MAX=4, status always 01:
  - Exactly 4 status bytes after 05.
  - wr_ack=1 with wr_err=1; spi_cs_n=1 afterwards.
- Contention:
  - After reset, rd_req and wr_req both assert in the same cycle and hold; each is re-requested after its ack.
  - Grant order is read, write, read, write.
  - No overlapping CS windows.
- init_done=0 with rd_req=1 for 100 cycles:
  - No byte_start; busy=0.
  - After init_done=1, the read starts within 2 cycles.
- ARESETn low mid-PROG after 3 bytes:
  - spi_cs_n=1 and byte_start=0 immediately.
  - A late byte_done is ignored; no ack.
  - After release, a fresh read completes normally.

Source files
------------

// File: rtl/spi_flash_sequencer_if.sv
// spi_flash_sequencer_if: requester ports and SPI byte-engine handshake of the flash sequencer.
interface spi_flash_sequencer_if #(parameter int DATA_SIZE = 32);
  logic init_done;
  logic rd_req, rd_ack;
  logic [23:0] rd_addr;
  logic [DATA_SIZE-1:0] rd_data;
  logic wr_req, wr_ack, wr_err;
  logic [23:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic byte_start, byte_done;
  logic [7:0] byte_tx, byte_rx;
  logic spi_cs_n, busy;
  modport slave (
    input  init_done, rd_req, rd_addr, wr_req, wr_addr, wr_data, byte_done, byte_rx,
    output rd_ack, rd_data, wr_ack, wr_err, byte_start, byte_tx, spi_cs_n, busy
  );
  modport master (
    output init_done, rd_req, rd_addr, wr_req, wr_addr, wr_data, byte_done, byte_rx,
    input  rd_ack, rd_data, wr_ack, wr_err, byte_start, byte_tx, spi_cs_n, busy
  );
endinterface

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: arbitrates read/program requesters and expands them into SPI flash command bytes.
module spi_flash_sequencer #(
  parameter int DATA_SIZE = 32,
  parameter int CS_GAP    = 2,
  parameter int POLL_MAX  = 1023
) (
  input logic ACLK,
  input logic ARESETn,
  spi_flash_sequencer_if.slave bus
);
  localparam int NB = DATA_SIZE / 8;
  typedef enum logic [3:0] {IDLE, GRANT, WREN, GAP1, PROG, GAP2, POLL, RD, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, total;
  logic [9:0] poll_q, poll_d;
  logic [23:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d, rd_data_q, rd_data_d;
  logic [7:0] tx_q, tx_d;
  logic start_q, start_d, wait_q, wait_d, cs_n_q, cs_n_d, wr_q, wr_d, err_q, err_d;
  logic cmd, fin;
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      poll_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      tx_q      <= '0;
      start_q   <= 1'b0;
      wait_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_q      <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      tx_q      <= tx_d;
      start_q   <= start_d;
      wait_q    <= wait_d;
      cs_n_q    <= cs_n_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
    end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    tx_d      = tx_q;
    start_d   = 1'b0;
    wait_d    = wait_q;
    cs_n_d    = cs_n_q;
    wr_d      = wr_q;
    err_d     = err_q;
    fin       = 1'b0;
    cmd       = state_q inside {WREN, PROG, POLL, RD};
    total     = state_q == WREN ? 4'd1 : 4'(4 + NB);
    case (state_q)
      IDLE: if (bus.init_done && (bus.rd_req || bus.wr_req)) begin
        wr_d    = bus.wr_req && (!bus.rd_req || !wr_q);
        state_d = GRANT;
      end
      GRANT: begin
        addr_d  = wr_q ? bus.wr_addr : bus.rd_addr;
        data_d  = bus.wr_data;
        state_d = wr_q ? WREN : RD;
      end
      GAP1, GAP2: begin
        cnt_d = cnt_q + 4'd1;
        if (int'(cnt_q) + 1 >= CS_GAP) begin
          cnt_d   = '0;
          state_d = state_q == GAP1 ? PROG : POLL;
        end
      end
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (cmd && !wait_q) begin
      start_d = 1'b1;
      wait_d  = 1'b1;
      cs_n_d  = 1'b0;
      // the poll counter tracks status bytes, so cnt only marks opcode vs status phase there
      cnt_d   = state_q == POLL ? (cnt_q == '0 ? 4'd1 : 4'd2) : cnt_q + 4'd1;
      tx_d    = cnt_q == '0 ? (state_q == WREN ? 8'h06 : state_q == PROG ? 8'h02 : state_q == POLL ? 8'h05 : 8'h03)
              : (state_q == POLL || (state_q == RD && cnt_q >= 4'd4)) ? 8'h00
              : cnt_q < 4'd4 ? addr_q[23:16] : data_q[DATA_SIZE-1 -: 8];
      addr_d  = (cnt_q != '0 && cnt_q < 4'd4) ? addr_q << 8 : addr_q;
      data_d  = (state_q == PROG && cnt_q >= 4'd4) ? data_q << 8 : data_q;
    end else if (cmd && bus.byte_done) begin
      wait_d = 1'b0;
      if (state_q == RD && cnt_q >= 4'd5) data_d = (data_q << 8) | DATA_SIZE'(bus.byte_rx);
      if (state_q == POLL && cnt_q == 4'd2) poll_d = poll_q + 10'd1;
      fin = state_q == POLL ? (cnt_q == 4'd2 && (!bus.byte_rx[0] || int'(poll_q) + 1 >= POLL_MAX)) : cnt_q == total;
      if (fin) begin
        cs_n_d    = 1'b1;
        cnt_d     = '0;
        poll_d    = '0;
        err_d     = state_q == POLL && bus.byte_rx[0];
        rd_data_d = state_q == RD ? data_d : rd_data_q;
        state_d   = state_q == WREN ? GAP1 : state_q == PROG ? GAP2 : DONE;
      end
    end
  end
  assign bus.rd_ack     = state_q == DONE && !wr_q;
  assign bus.wr_ack     = state_q == DONE && wr_q;
  assign bus.wr_err     = state_q == DONE && wr_q && err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.byte_start = start_q;
  assign bus.byte_tx    = tx_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb_spi_flash_sequencer: directed plus randomized checks of command framing, arbitration, polling and reset.
module tb_spi_flash_sequencer;
  localparam int DS = 32, NB = DS / 8, GAP = 2, PMAX = 4;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;
  spi_flash_sequencer_if #(.DATA_SIZE(DS)) bus();
  spi_flash_sequencer #(.DATA_SIZE(DS), .CS_GAP(GAP), .POLL_MAX(PMAX)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));
  int total = 0, passed = 0, fails = 0, viol = 0, nstart = 0;
  int eng_lat = 3, eng_left = 0, hi = 0, cur = 0;
  bit prev_cs = 1'b1, inj = 1'b0;
  logic [7:0] rx_q[$];
  int tx_log[$], win_len[$], ack_log[$], exp_tx[$], exp_len[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // byte engine responder and bus monitor, both sampled away from the rising edge
  initial begin
    bus.byte_done = 1'b0;
    bus.byte_rx   = 8'h00;
    forever begin
      @(negedge ACLK);
      if (bus.byte_start === 1'b1) begin
        tx_log.push_back(int'(bus.byte_tx));
        nstart++;
        if (bus.spi_cs_n !== 1'b0) viol++;
      end
      if (prev_cs && bus.spi_cs_n === 1'b0) begin
        if (hi < GAP) viol++;
        cur = 0;
      end
      if (bus.spi_cs_n === 1'b0 && bus.byte_start === 1'b1) cur++;
      if (!prev_cs && bus.spi_cs_n === 1'b1) win_len.push_back(cur);
      hi = (bus.spi_cs_n === 1'b1) ? hi + 1 : 0;
      prev_cs = (bus.spi_cs_n !== 1'b0);
      if (bus.rd_ack === 1'b1) ack_log.push_back(0);
      if (bus.wr_ack === 1'b1) ack_log.push_back(1);
      bus.byte_done = 1'b0;
      if (inj) begin
        bus.byte_done = 1'b1;
        inj = 1'b0;
      end else if (bus.byte_start === 1'b1) begin
        if (eng_left > 0) viol++;
        eng_left = eng_lat;
      end else if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin
          bus.byte_done = 1'b1;
          bus.byte_rx   = rx_q.size() > 0 ? rx_q.pop_front() : 8'h00;
        end
      end
    end
  end

  task automatic clear_logs();
    tx_log.delete(); win_len.delete(); ack_log.delete(); exp_tx.delete(); exp_len.delete();
  endtask

  task automatic model_read(input logic [23:0] a);
    exp_len.push_back(4 + NB);
    exp_tx.push_back(3);
    for (int i = 2; i >= 0; i--) exp_tx.push_back(int'((a >> (8 * i)) & 24'hFF));
    for (int i = 0; i < NB; i++) exp_tx.push_back(0);
  endtask

  task automatic model_prog(input logic [23:0] a, input logic [DS-1:0] d, input int k);
    exp_len.push_back(1);
    exp_tx.push_back(6);
    exp_len.push_back(4 + NB);
    exp_tx.push_back(2);
    for (int i = 2; i >= 0; i--) exp_tx.push_back(int'((a >> (8 * i)) & 24'hFF));
    for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(int'((d >> (8 * i)) & DS'(255)));
    exp_len.push_back(1 + k);
    exp_tx.push_back(5);
    for (int i = 0; i < k; i++) exp_tx.push_back(-1);
  endtask

  task automatic cmp_windows(input string tag);
    chk({tag, "_nwin"}, 64'(win_len.size()), 64'(exp_len.size()));
    chk({tag, "_nbytes"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < win_len.size() && i < exp_len.size(); i++)
      chk($sformatf("%s_wlen%0d", tag, i), 64'(win_len[i]), 64'(exp_len[i]));
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      if (exp_tx[i] >= 0) chk($sformatf("%s_tx%0d", tag, i), 64'(tx_log[i]), 64'(exp_tx[i]));
    chk({tag, "_protocol"}, 64'(viol), 64'd0);
  endtask

  task automatic wait_ack(input bit wr, output bit ok, output logic [63:0] v);
    ok = 1'b0;
    v = '0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge ACLK);
      if (wr ? bus.wr_ack === 1'b1 : bus.rd_ack === 1'b1) begin
        ok = 1'b1;
        v = wr ? 64'(bus.wr_err) : 64'(bus.rd_data);
      end
    end
  endtask

  task automatic prep_read(input logic [23:0] a, input logic [DS-1:0] d);
    rx_q.delete();
    for (int i = 0; i < 4; i++) rx_q.push_back(8'h00);
    for (int i = NB - 1; i >= 0; i--) rx_q.push_back(8'((d >> (8 * i)) & DS'(255)));
    model_read(a);
  endtask

  task automatic finish_read(input logic [DS-1:0] d, input string tag);
    bit ok;
    logic [63:0] v;
    wait_ack(1'b0, ok, v);
    bus.rd_req = 1'b0;
    chk({tag, "_ack"}, 64'(ok), 64'd1);
    chk({tag, "_data"}, v, 64'(d));
    repeat (3) @(negedge ACLK);
    chk({tag, "_held"}, 64'(bus.rd_data), 64'(d));
    cmp_windows(tag);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [DS-1:0] d, input int lat, input string tag);
    clear_logs();
    eng_lat = lat;
    prep_read(a, d);
    bus.rd_addr = a;
    bus.rd_req = 1'b1;
    finish_read(d, tag);
  endtask

  task automatic prep_prog(input logic [23:0] a, input logic [DS-1:0] d, input logic [63:0] sts, input int n, output bit err);
    int k;
    logic [7:0] s;
    rx_q.delete();
    for (int i = 0; i < 6 + NB; i++) rx_q.push_back(8'h00);
    for (int i = 0; i < n; i++) rx_q.push_back(sts[8*i +: 8]);
    k = 0;
    err = 1'b1;
    for (int i = 0; i < PMAX; i++) begin
      s = i < n ? sts[8*i +: 8] : 8'h00;
      k++;
      if (!s[0]) begin
        err = 1'b0;
        break;
      end
    end
    model_prog(a, d, k);
  endtask

  task automatic do_prog(input logic [23:0] a, input logic [DS-1:0] d, input logic [63:0] sts, input int n, input int lat, input string tag);
    bit ok, err;
    logic [63:0] v;
    clear_logs();
    eng_lat = lat;
    prep_prog(a, d, sts, n, err);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req = 1'b1;
    wait_ack(1'b1, ok, v);
    bus.wr_req = 1'b0;
    chk({tag, "_ack"}, 64'(ok), 64'd1);
    chk({tag, "_err"}, v, 64'(err));
    repeat (3) @(negedge ACLK);
    chk({tag, "_cs_idle"}, 64'(bus.spi_cs_n), 64'd1);
    cmp_windows(tag);
  endtask

  initial begin
    int bad, got, base, nack, last;
    bit ok, err;
    logic [DS-1:0] d;
    logic [63:0] sts;
    bus.init_done = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_cs_n", 64'(bus.spi_cs_n), 64'd1);
    chk("rst_byte_start", 64'(bus.byte_start), 64'd0);
    chk("rst_byte_tx", 64'(bus.byte_tx), 64'd0);
    chk("rst_rd_ack", 64'(bus.rd_ack), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_wr_ack", 64'(bus.wr_ack), 64'd0);
    chk("rst_wr_err", 64'(bus.wr_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    ARESETn = 1'b1;
    inj = 1'b1;
    repeat (5) @(negedge ACLK);
    chk("stray_done_busy", 64'(bus.busy), 64'd0);
    chk("stray_done_start", 64'(nstart), 64'd0);

    clear_logs();
    bus.rd_addr = 24'h0A0B0C;
    bus.rd_req = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge ACLK);
      if (bus.busy !== 1'b0 || bus.byte_start !== 1'b0) bad++;
    end
    chk("init_gate_idle", 64'(bad), 64'd0);
    eng_lat = 2;
    d = DS'(32'h1234_5678);
    prep_read(24'h0A0B0C, d);
    bus.init_done = 1'b1;
    got = 0;
    for (int n = 0; n < 2 && got == 0; n++) begin
      @(negedge ACLK);
      if (bus.busy === 1'b1) got = 1;
    end
    chk("init_grant_latency", 64'(got), 64'd1);
    finish_read(d, "init_read");

    do_read(24'h012345, DS'(32'hDEAD_BEEF), 16, "read");
    do_prog(24'h000100, DS'(32'hA5A5_5A5A), 64'h00_03_03, 3, 3, "prog");
    do_prog(24'h00ABCD, DS'(32'h0F0F_F0F0), 64'h01_01_01_01_01_01, 6, 2, "timeout");

    clear_logs();
    rx_q.delete();
    eng_lat = 2;
    bus.rd_addr = 24'h111111;
    bus.wr_addr = 24'h222222;
    bus.wr_data = DS'(32'hC0DE_CAFE);
    last = 1;
    for (int i = 0; i < 4; i++) begin
      last = 1 - last;
      if (last == 0) model_read(24'h111111);
      else model_prog(24'h222222, DS'(32'hC0DE_CAFE), 1);
    end
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    nack = 0;
    for (int n = 0; n < 6000 && nack < 4; n++) begin
      @(negedge ACLK);
      nack += int'(bus.rd_ack === 1'b1) + int'(bus.wr_ack === 1'b1);
      bus.rd_req = nack < 4 && bus.rd_ack !== 1'b1;
      bus.wr_req = nack < 4 && bus.wr_ack !== 1'b1;
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    repeat (4) @(negedge ACLK);
    chk("cont_nack", 64'(ack_log.size()), 64'd4);
    last = 1;
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      last = 1 - last;
      chk($sformatf("cont_order%0d", i), 64'(ack_log[i]), 64'(last));
    end
    chk("cont_busy", 64'(bus.busy), 64'd0);
    cmp_windows("cont");

    for (int r = 0; r < 10; r++) begin
      d = DS'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 0) do_read(24'($urandom), d, $urandom_range(1, 6), $sformatf("rnd%0d_rd", r));
      else begin
        sts = {$urandom, $urandom};
        do_prog(24'($urandom), d, sts, $urandom_range(1, 6), $urandom_range(1, 6), $sformatf("rnd%0d_wr", r));
      end
    end

    clear_logs();
    eng_lat = 8;
    prep_prog(24'h345678, DS'(32'h1122_3344), 64'h00, 1, err);
    bus.wr_addr = 24'h345678;
    bus.wr_data = DS'(32'h1122_3344);
    base = nstart;
    bus.wr_req = 1'b1;
    for (int n = 0; n < 2000 && nstart - base < 4; n++) @(negedge ACLK);
    chk("mid_prog_reached", 64'(nstart - base), 64'd4);
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_rst_cs_n", 64'(bus.spi_cs_n), 64'd1);
    chk("async_rst_start", 64'(bus.byte_start), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    bus.wr_req = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    base = nstart;
    clear_logs();
    repeat (12) @(negedge ACLK);
    chk("late_done_busy", 64'(bus.busy), 64'd0);
    chk("late_done_start", 64'(nstart - base), 64'd0);
    chk("late_done_noack", 64'(ack_log.size()), 64'd0);
    do_read(24'h00FEED, DS'(32'h8765_4321), 3, "post_rst_read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
